// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: access function codes,
// response ownership states and the data alignment check.
package mem_pkg;

    localparam logic [2:0] FUNC_B  = 3'b000;
    localparam logic [2:0] FUNC_H  = 3'b001;
    localparam logic [2:0] FUNC_W  = 3'b010;
    localparam logic [2:0] FUNC_BU = 3'b100;
    localparam logic [2:0] FUNC_HU = 3'b101;

    // Who owns the memory read data returning in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_I     = 2'd1,
        OWN_D     = 2'd2,
        OWN_D_ERR = 2'd3
    } owner_t;

    // Only the size field and the two low address bits decide alignment.
    function automatic logic is_misaligned(input logic [1:0] func, input logic [1:0] addr);
        logic r_mis;
        r_mis = 1'b0;
        case (func)
            2'b01:   r_mis = addr[0];
            2'b10:   r_mis = (addr != 2'b00);
            default: r_mis = 1'b0;
        endcase
        return r_mis;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory command buses around the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_rw;
    logic [2:0]  mem_func;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_rw, mem_func, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_func, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_rw, mem_func, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_fairness.sv
// Grant decision between fetch and data requesters. Data normally wins, but
// after STARVE_LIMIT consecutive data grants with a fetch waiting, fetch is
// forced through once.
module mem_arb_fairness #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_nxt;
    logic          w_d_gnt;
    logic          w_if_gnt;

    // Grant decision: data has priority unless fetch has been starved too long.
    always_comb begin
        w_d_gnt  = i_d_req & ((r_starve_cnt < LIMIT) | ~i_if_req);
        w_if_gnt = i_if_req & ~w_d_gnt;
    end

    // Starvation counter next value: counts data grants that bypass a waiting fetch.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_if_gnt || !i_if_req) begin
            w_starve_nxt = {CW{1'b0}};
        end else if (w_d_gnt && (r_starve_cnt != LIMIT)) begin
            w_starve_nxt = r_starve_cnt + CW'(1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {CW{1'b0}};
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    assign o_if_gnt = w_if_gnt;
    assign o_d_gnt  = w_d_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: picks fetch or load/store each cycle, drives the
// memory command bus, and steers the registered read data back to its owner
// one cycle after the grant. Misaligned data accesses never write memory and
// return an error response instead.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_d_mis;
    logic        w_d_store;
    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic        w_if_rvalid;
    logic        w_d_rvalid;
    logic        w_d_err;
    logic        w_mem_rw;
    logic [2:0]  w_mem_func;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;

    mem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fairness (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_if_req (bus.if_req),
        .i_d_req  (bus.d_req),
        .o_if_gnt (w_if_gnt),
        .o_d_gnt  (w_d_gnt)
    );

    assign w_d_mis   = is_misaligned(bus.d_func[1:0], bus.d_addr[1:0]);
    assign w_d_store = w_d_gnt & bus.d_we & ~w_d_mis;

    // Owner state register: remembers who the next cycle's read data belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Owner next state: follows this cycle's grant; good stores expect no response.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_d_gnt) begin
            if (w_d_mis) begin
                w_owner_nxt = OWN_D_ERR;
            end else if (bus.d_we) begin
                w_owner_nxt = OWN_NONE;
            end else begin
                w_owner_nxt = OWN_D;
            end
        end else if (w_if_gnt) begin
            w_owner_nxt = OWN_I;
        end else begin
            w_owner_nxt = OWN_NONE;
        end
    end

    // Response decode from the owner state.
    always_comb begin
        w_if_rvalid = 1'b0;
        w_d_rvalid  = 1'b0;
        w_d_err     = 1'b0;
        case (r_owner)
            OWN_I: begin
                w_if_rvalid = 1'b1;
            end
            OWN_D: begin
                w_d_rvalid = 1'b1;
            end
            OWN_D_ERR: begin
                w_d_rvalid = 1'b1;
                w_d_err    = 1'b1;
            end
            default: begin
                w_if_rvalid = 1'b0;
                w_d_rvalid  = 1'b0;
                w_d_err     = 1'b0;
            end
        endcase
    end

    // Command mux: the granted requester drives memory; a misaligned data
    // access is turned into a harmless read; idle parks on the fetch address.
    always_comb begin
        w_mem_rw    = 1'b0;
        w_mem_func  = FUNC_W;
        w_mem_addr  = bus.if_addr;
        w_mem_wdata = 32'd0;
        if (w_d_gnt) begin
            w_mem_rw    = w_d_store;
            w_mem_func  = bus.d_func;
            w_mem_addr  = bus.d_addr;
            w_mem_wdata = w_d_store ? bus.d_wdata : 32'd0;
        end else if (w_if_gnt) begin
            w_mem_rw    = 1'b0;
            w_mem_func  = FUNC_W;
            w_mem_addr  = bus.if_addr;
            w_mem_wdata = 32'd0;
        end else begin
            w_mem_rw    = 1'b0;
            w_mem_func  = FUNC_W;
            w_mem_addr  = bus.if_addr;
            w_mem_wdata = 32'd0;
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.d_err     = w_d_err;
    assign bus.d_rdata   = w_d_err ? 32'd0 : bus.mem_rdata;
    assign bus.mem_rw    = w_mem_rw;
    assign bus.mem_func  = w_mem_func;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word-array memory model on the command bus, and a
// byte-level reference memory plus grant-rule model that predicts every
// grant, command and response. Directed scenarios first, then random traffic.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model (word array, registered read) ----------
    logic [31:0] mem_words [1024];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;

    function automatic logic [31:0] mm_read(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f);
        logic [31:0] r;
        r = w >> (8 * int'(off));
        case (f[1:0])
            2'b00:   r = f[2] ? {24'd0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            2'b01:   r = f[2] ? {16'd0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mm_write(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(off);
        mask = (f[1:0] == 2'b00) ? 32'h0000_00FF : (f[1:0] == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    always @(posedge clk) begin
        if (pl_en)
            mem_words[pl_idx] <= pl_val;
        else if (bus.mem_rw)
            mem_words[bus.mem_addr[11:2]] <= mm_write(mem_words[bus.mem_addr[11:2]], bus.mem_addr[1:0], bus.mem_func, bus.mem_wdata);
        bus.mem_rdata <= mm_read(mem_words[bus.mem_addr[11:2]], bus.mem_addr[1:0], bus.mem_func);
    end

    // ---------------- reference model ------------------------------------
    logic [7:0]  ref_mem [4096];
    int          m_run;
    logic        exp_i_valid, exp_d_valid, exp_d_err;
    logic [31:0] exp_i_data, exp_d_data;
    logic        obs_i_valid, obs_d_valid, obs_d_err, obs_if_gnt, obs_d_gnt, obs_mem_rw;
    logic [31:0] obs_i_data, obs_d_data;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return 1 << int'(f[1:0]);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] addr);
        int a;
        int n;
        logic [31:0] v;
        a = int'(addr & 32'hFFF);
        n = nbytes(f);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + k) % 4096]) << (8 * k));
        if (!f[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] wd);
        int a;
        a = int'(addr & 32'hFFF);
        for (int k = 0; k < nbytes(f); k++) ref_mem[(a + k) % 4096] = wd[8 * k +: 8];
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = 10'(idx);
        pl_val = val;
        for (int k = 0; k < 4; k++) ref_mem[idx * 4 + k] = val[8 * k +: 8];
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic clear_model();
        m_run = 0;
        exp_i_valid = 1'b0; exp_d_valid = 1'b0; exp_d_err = 1'b0;
        exp_i_data = 32'd0; exp_d_data = 32'd0;
    endtask

    // One clock cycle: inputs already driven at the negedge.
    task automatic step();
        logic eg_d, eg_i, mis;
        #1;
        obs_i_valid = bus.if_rvalid; obs_i_data = bus.if_rdata;
        obs_d_valid = bus.d_rvalid;  obs_d_err  = bus.d_err; obs_d_data = bus.d_rdata;
        obs_if_gnt  = bus.if_gnt;    obs_d_gnt  = bus.d_gnt; obs_mem_rw = bus.mem_rw;
        chk("if_rvalid", bus.if_rvalid, exp_i_valid);
        if (exp_i_valid) chk("if_rdata", bus.if_rdata, exp_i_data);
        chk("d_rvalid", bus.d_rvalid, exp_d_valid);
        chk("d_err", bus.d_err, exp_d_err);
        if (exp_d_valid) chk("d_rdata", bus.d_rdata, exp_d_data);

        eg_d = bus.d_req && (m_run < LIMIT || !bus.if_req);
        eg_i = !eg_d && bus.if_req;
        mis  = (int'(bus.d_addr & 32'h3) % nbytes(bus.d_func)) != 0;
        chk("d_gnt", bus.d_gnt, eg_d);
        chk("if_gnt", bus.if_gnt, eg_i);
        chk("mem_rw", bus.mem_rw, eg_d && bus.d_we && !mis);
        if (eg_d) begin
            chk("mem_addr_d", bus.mem_addr, bus.d_addr);
            chk("mem_func_d", bus.mem_func, bus.d_func);
            if (bus.d_we && !mis) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
        end else begin
            chk("mem_addr_i", bus.mem_addr, bus.if_addr);
            chk("mem_func_i", bus.mem_func, 32'd2);
        end

        exp_i_valid = eg_i;
        exp_i_data  = ref_load(3'b010, bus.if_addr);
        exp_d_valid = eg_d && (mis || !bus.d_we);
        exp_d_err   = eg_d && mis;
        exp_d_data  = mis ? 32'd0 : ref_load(bus.d_func, bus.d_addr);
        if (eg_d && bus.d_we && !mis) ref_store(bus.d_func, bus.d_addr, bus.d_wdata);
        if (eg_d && bus.if_req) m_run = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
        else m_run = 0;
        @(negedge clk);
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_func = f; bus.d_addr = a; bus.d_wdata = wd;
    endtask

    logic [2:0] ld_funcs [5];

    initial begin
        ld_funcs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0;
        pl_en = 1'b0; pl_idx = 10'd0; pl_val = 32'd0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        clear_model();
        @(negedge clk);
        for (int i = 0; i < 1024; i++) preload(i, $urandom);
        preload(32'h40, 32'hDEAD_BEEF);
        preload(32'h41, 32'hCAFE_F00D);
        preload(32'h80, 32'h1122_3344);
        preload(32'hC0, 32'h5566_7788);

        // reset state
        #1;
        chk("rst_if_gnt", bus.if_gnt, 32'd0);
        chk("rst_d_gnt", bus.d_gnt, 32'd0);
        chk("rst_if_rvalid", bus.if_rvalid, 32'd0);
        chk("rst_d_rvalid", bus.d_rvalid, 32'd0);
        chk("rst_d_err", bus.d_err, 32'd0);
        chk("rst_mem_rw", bus.mem_rw, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // fetch only, back to back
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        step();
        chk("fetch0_gnt", obs_if_gnt, 32'd1);
        bus.if_addr = 32'h104;
        step();
        chk("fetch0_rvalid", obs_i_valid, 32'd1);
        chk("fetch0_rdata", obs_i_data, 32'hDEAD_BEEF);
        bus.if_req = 1'b0;
        step();
        chk("fetch1_rvalid", obs_i_valid, 32'd1);
        chk("fetch1_rdata", obs_i_data, 32'hCAFE_F00D);
        step();

        // contention: D,D,D,D,I repeated
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        drive_d(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("contention_d_gnt", obs_d_gnt, (k % 5 != 4) ? 32'd1 : 32'd0);
        end
        bus.if_req = 1'b0;
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        step();
        step();

        // store byte then load word
        drive_d(1'b1, 1'b1, 3'b000, 32'h203, 32'h0000_00AB);
        step();
        chk("sb_mem_rw", obs_mem_rw, 32'd1);
        drive_d(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
        step();
        chk("lw_mem_rw", obs_mem_rw, 32'd0);
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        step();
        chk("lw_after_sb", obs_d_data, 32'hAB22_3344);

        // sign / zero extension
        drive_d(1'b1, 1'b1, 3'b010, 32'h200, 32'h8001_0000);
        step();
        drive_d(1'b1, 1'b0, 3'b001, 32'h202, 32'd0);
        step();
        drive_d(1'b1, 1'b0, 3'b101, 32'h202, 32'd0);
        step();
        chk("lh_data", obs_d_data, 32'hFFFF_8001);
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        step();
        chk("lhu_data", obs_d_data, 32'h0000_8001);

        // misaligned store
        drive_d(1'b1, 1'b1, 3'b010, 32'h302, 32'h1234_5678);
        step();
        chk("mis_d_gnt", obs_d_gnt, 32'd1);
        chk("mis_mem_rw", obs_mem_rw, 32'd0);
        drive_d(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        step();
        chk("mis_rvalid", obs_d_valid, 32'd1);
        chk("mis_err", obs_d_err, 32'd1);
        chk("mis_rdata", obs_d_data, 32'd0);
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        step();
        chk("mis_mem_unchanged", obs_d_data, 32'h5566_7788);

        // reset in the middle of a load
        drive_d(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        step();
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_d_rvalid", bus.d_rvalid, 32'd0);
        clear_model();
        @(negedge clk);
        #1;
        chk("midrst_d_rvalid_hold", bus.d_rvalid, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("postrst_mem_rw", obs_mem_rw, 32'd0);
        step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (!bus.if_req || obs_if_gnt) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (!bus.d_req || obs_d_gnt) begin
                logic we;
                we = 1'($urandom_range(0, 1));
                drive_d(($urandom_range(0, 2) != 0), we,
                        we ? ld_funcs[$urandom_range(0, 2)] : ld_funcs[$urandom_range(0, 4)],
                        ($urandom_range(0, 9) < 3) ? 32'($urandom_range(0, 4095))
                                                   : (32'($urandom_range(0, 1023)) << 2),
                        $urandom);
            end
            step();
        end
        bus.if_req = 1'b0;
        drive_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
